// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response handshake and data-memory bus of the load/store unit
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_error;
  logic [31:0] load_data;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_read_data;
  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_error, load_data, mem_address, mem_write_data, mem_write, mem_read
  );
  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_error, load_data, mem_address, mem_write_data, mem_write, mem_read
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word loads and stores over a word-wide big-endian data memory,
// sub-word stores done as read-modify-write
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input logic              clk,
  input logic              reset,
  input logic              clock_enable,
  load_store_unit_if.slave bus
);
  localparam logic [31:0] ADDR_MAX = 32'(MEM_BYTES - 4);
  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, DONE} state_e;
  state_e      state_q, state_d;
  logic        write_q, unsigned_q, error_q, error_d, req_err, active;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, wbuf_q, wbuf_d, load_data_q, load_data_d;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] extracted, lane_mask, lane_data, merged;
  assign req_err = bus.req_size == 2'b11
                || (bus.req_size == 2'b01 && bus.req_addr[0])
                || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
                || bus.req_addr > ADDR_MAX;
  // byte offset 0 is the most significant lane
  assign byte_lane = bus.mem_read_data[{~addr_q[1:0], 3'b000} +: 8];
  assign half_lane = addr_q[1] ? bus.mem_read_data[15:0] : bus.mem_read_data[31:16];
  assign extracted = size_q == 2'b00 ? {{24{~unsigned_q & byte_lane[7]}}, byte_lane}
                   : size_q == 2'b01 ? {{16{~unsigned_q & half_lane[15]}}, half_lane}
                   : bus.mem_read_data;
  assign lane_mask = size_q == 2'b00 ? 32'h0000_00ff << {~addr_q[1:0], 3'b000}
                   : addr_q[1] ? 32'h0000_ffff : 32'hffff_0000;
  assign lane_data = size_q == 2'b00 ? {4{wdata_q[7:0]}} : {2{wdata_q[15:0]}};
  assign merged = (bus.mem_read_data & ~lane_mask) | (lane_data & lane_mask);
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      error_q     <= 1'b0;
      load_data_q <= '0;
      wbuf_q      <= '0;
    end else if (clock_enable) begin
      state_q     <= state_d;
      error_q     <= error_d;
      load_data_q <= load_data_d;
      wbuf_q      <= wbuf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (reset && clock_enable && state_q == IDLE && bus.req_valid) begin
      write_q    <= bus.req_write;
      size_q     <= bus.req_size;
      unsigned_q <= bus.req_unsigned;
      addr_q     <= bus.req_addr;
      wdata_q    <= bus.req_wdata;
    end
  end
  always_comb begin
    state_d     = state_q;
    error_d     = error_q;
    wbuf_d      = wbuf_q;
    load_data_d = load_data_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        error_d = req_err;
        state_d = req_err ? DONE : !bus.req_write ? LOAD : bus.req_size == 2'b10 ? WRITE : RMW_RD;
      end
      LOAD: begin
        load_data_d = extracted;
        state_d     = DONE;
      end
      RMW_RD: begin
        wbuf_d  = merged;
        state_d = WRITE;
      end
      WRITE:   state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  assign active             = state_q == LOAD || state_q == RMW_RD || state_q == WRITE;
  assign bus.req_ready      = state_q == IDLE;
  assign bus.resp_valid     = state_q == DONE;
  assign bus.resp_error     = error_q;
  assign bus.load_data      = load_data_q;
  assign bus.mem_address    = active ? {addr_q[31:2], 2'b00} : '0;
  // word stores bypass the merge buffer and write the captured data directly
  assign bus.mem_write_data = state_q == WRITE ? (size_q == 2'b10 ? wdata_q : wbuf_q) : '0;
  assign bus.mem_read       = reset && (state_q == LOAD || state_q == RMW_RD);
  assign bus.mem_write      = reset && clock_enable && write_q && state_q == WRITE;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit with a byte-array reference memory
module tb_load_store_unit;
  localparam int MEM_BYTES = 4096;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clock_enable = 1'b1;
  always #5 clk = ~clk;
  load_store_unit_if bus();
  load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk(clk), .reset(reset), .clock_enable(clock_enable), .bus(bus)
  );
  logic [31:0] mem [0:MEM_BYTES/4-1];
  logic [7:0]  ref_mem [0:MEM_BYTES-1];
  assign bus.mem_read_data = mem[bus.mem_address[11:2]];
  always @(posedge clk) if (bus.mem_write) mem[bus.mem_address[11:2]] <= bus.mem_write_data;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    bit          err;
    bit          load;
    logic [31:0] data;
    int          acc;
    int          lat;
    int          acts;
  } exp_t;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int mem_acts = 0;
  int mem_writes = 0;
  logic [31:0] last_load = '0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask
  function automatic bit ref_err(input logic [1:0] sz, input logic [31:0] a);
    return sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0) || a > 32'(MEM_BYTES - 4);
  endfunction
  function automatic int nbytes(input logic [1:0] sz);
    return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
  endfunction
  function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit u, input logic [31:0] a);
    logic [31:0] v = '0;
    for (int i = 0; i < nbytes(sz); i++) v = (v << 8) | 32'(ref_mem[a + i]);
    if (!u && sz == 2'd0 && v >= 32'h80) v = v | 32'hFFFF_FF00;
    if (!u && sz == 2'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
    return v;
  endfunction
  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < nbytes(sz); i++) ref_mem[a + i] = 8'(d >> (8 * (nbytes(sz) - 1 - i)));
  endtask
  function automatic logic [31:0] ref_word(input int w);
    return {ref_mem[4*w], ref_mem[4*w+1], ref_mem[4*w+2], ref_mem[4*w+3]};
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (!reset) last_load = '0;
    if (bus.mem_read || bus.mem_write) begin
      mem_acts++;
      check("rw_exclusive", 32'(bus.mem_read & bus.mem_write), 0);
    end
    if (bus.mem_write) mem_writes++;
    if (bus.resp_valid) begin
      if (sb.size() == 0) check("resp_unexpected", 32'(bus.resp_valid), 0);
      else begin
        e = sb.pop_front();
        check("resp_error", 32'(bus.resp_error), 32'(e.err));
        check("latency", 32'(cyc - e.acc), 32'(e.lat));
        if (e.err) check("err_mem_touch", 32'(mem_acts), 32'(e.acts));
        if (e.load && !e.err) begin
          check("load_data", bus.load_data, e.data);
          last_load = e.data;
        end else check("load_data_hold", bus.load_data, last_load);
      end
    end
  end
  task automatic do_req(input bit w, input logic [1:0] sz, input bit u, input logic [31:0] a,
                        input logic [31:0] d, input int freeze);
    exp_t e;
    int n;
    e.err  = ref_err(sz, a);
    e.load = !w;
    e.lat  = e.err ? 1 : (!w || sz == 2'd2) ? 2 + freeze : 3 + freeze;
    e.data = (!e.err && !w) ? ref_load(sz, u, a) : '0;
    if (!e.err && w) ref_store(sz, a, d);
    @(negedge clk);
    bus.req_write = w; bus.req_size = sz; bus.req_unsigned = u;
    bus.req_addr = a; bus.req_wdata = d; bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    if (!bus.req_ready) begin
      check("req_ready_timeout", 32'(bus.req_ready), 1);
      bus.req_valid = 1'b0;
      return;
    end
    e.acc = cyc; e.acts = mem_acts;
    sb.push_back(e);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    if (freeze > 0 && !e.err) begin
      @(negedge clk);
      clock_enable = 1'b0;
      repeat (freeze) begin
        @(negedge clk);
        if (w) check("freeze_mem_write", 32'(bus.mem_write), 0);
        else check("freeze_mem_read", 32'(bus.mem_read), 1);
      end
      clock_enable = 1'b1;
    end
    n = 0;
    while (sb.size() > 0 && n < 40) begin @(negedge clk); n++; end
    if (sb.size() > 0) begin
      check("resp_timeout", 32'(sb.size()), 0);
      sb.delete();
    end
  endtask
  initial begin
    logic [31:0] saved, a, d;
    logic [1:0]  sz;
    int          wb, r, fz;
    bit          w;
    for (int i = 0; i < MEM_BYTES/4; i++) mem[i] <= '0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = '0;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = '0;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 1);
    check("rst_resp_valid", 32'(bus.resp_valid), 0);
    check("rst_load_data", bus.load_data, 0);
    check("rst_mem_strobes", 32'({bus.mem_read, bus.mem_write}), 0);
    reset = 1'b1;
    do_req(1, 2'd2, 0, 32'h10, 32'hAABBCCDD, 0);
    do_req(0, 2'd2, 0, 32'h10, 0, 0);
    check("lw_0x10", bus.load_data, 32'hAABBCCDD);
    do_req(1, 2'd0, 0, 32'h11, 32'h55, 0);
    check("mem_0x10_sb", mem[4], 32'hAA55CCDD);
    do_req(0, 2'd0, 0, 32'h11, 0, 0);
    check("lb_0x11", bus.load_data, 32'h00000055);
    do_req(0, 2'd0, 1, 32'h10, 0, 0);
    check("lbu_0x10", bus.load_data, 32'h000000AA);
    do_req(0, 2'd0, 0, 32'h10, 0, 0);
    check("lb_0x10", bus.load_data, 32'hFFFFFFAA);
    do_req(1, 2'd1, 0, 32'h12, 32'h8001, 0);
    do_req(0, 2'd1, 0, 32'h12, 0, 0);
    check("lh_0x12", bus.load_data, 32'hFFFF8001);
    do_req(0, 2'd1, 1, 32'h12, 0, 0);
    check("lhu_0x12", bus.load_data, 32'h00008001);
    check("mem_0x10_sh", mem[4], 32'hAA558001);
    do_req(0, 2'd2, 0, 32'h13, 0, 0);
    do_req(1, 2'd1, 0, 32'h11, 32'h1234, 0);
    do_req(0, 2'd2, 0, 32'hFFD, 0, 0);
    do_req(0, 2'd3, 0, 32'h10, 0, 0);
    do_req(1, 2'd0, 0, 32'hFFF, 32'h99, 0);
    check("mem_after_errors", mem[4], 32'hAA558001);
    saved = mem[4];
    wb = mem_writes;
    @(negedge clk);
    bus.req_write = 1'b1; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
    bus.req_addr = 32'h12; bus.req_wdata = 32'h77; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    check("rmw_rd_mem_read", 32'(bus.mem_read), 1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check("abort_word", mem[4], saved);
    check("abort_no_write", 32'(mem_writes), 32'(wb));
    check("abort_req_ready", 32'(bus.req_ready), 1);
    check("abort_load_data", bus.load_data, 0);
    do_req(0, 2'd2, 0, 32'h10, 0, 3);
    check("frozen_lw", bus.load_data, 32'hAA558001);
    for (int k = 0; k < 120; k++) begin
      w  = 1'($urandom_range(0, 1));
      sz = $urandom_range(0, 7) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
      r  = $urandom_range(0, 9);
      a  = r == 0 ? 32'($urandom_range(4084, 4100)) : 32'($urandom_range(0, 63));
      if (r != 1 && sz == 2'd1) a[0] = 1'b0;
      if (r != 1 && sz == 2'd2) a[1:0] = 2'b00;
      d  = $urandom;
      fz = $urandom_range(0, 3) == 0 ? $urandom_range(1, 2) : 0;
      do_req(w, sz, 1'($urandom_range(0, 1)), a, d, ref_err(sz, a) ? 0 : fz);
    end
    @(negedge clk);
    for (int i = 0; i < 16; i++) check($sformatf("mem_word_%0d", i), mem[i], ref_word(i));
    check("mem_word_top", mem[MEM_BYTES/4-1], ref_word(MEM_BYTES/4-1));
    check("sb_empty", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
